// File: rtl/aes_mix_column_engine.sv
// Iterative AES (Inv)MixColumns engine: COLS_PER_CYCLE columns per RUN cycle, valid/ready on both sides.
// Optional macro MIXCOL_INV_EN builds the InvMixColumns pre-map and honours the mode input.
module aes_mix_column_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // A step of 4 truncates to 0, so col_cnt stays at 0 for the single-cycle build.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  state_t       state, state_next;
  logic [127:0] work;
  logic [127:0] mixed;
  logic [31:0]  col;
  logic [1:0]   col_cnt;
  logic         last_group;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a, b, cc, d, t;
    {a, b, cc, d} = c;
    t = a ^ b ^ cc ^ d;
    return {a ^ t ^ xtime(a ^ b), b ^ t ^ xtime(b ^ cc),
            cc ^ t ^ xtime(cc ^ d), d ^ t ^ xtime(d ^ a)};
  endfunction

`ifdef MIXCOL_INV_EN
  logic inv_q;

  // InvMixColumns = MixColumns after folding 4*(a^c) / 4*(b^d) into the column.
  function automatic logic [31:0] pre_map(input logic [31:0] c);
    logic [7:0] a, b, cc, d, u, v;
    {a, b, cc, d} = c;
    u = xtime(xtime(a ^ cc));
    v = xtime(xtime(b ^ d));
    return {a ^ u, b ^ v, cc ^ u, d ^ v};
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign last_group = ({1'b0, col_cnt} + 3'(COLS_PER_CYCLE)) >= 3'd4;

  // NOTE: every variable driven here gets a default first, so no path can leave a latch behind.
  always_comb begin
    mixed = work;
    col   = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col = work[127 - 32*(int'(col_cnt) + k) -: 32];
`ifdef MIXCOL_INV_EN
      if (inv_q) col = pre_map(col);
`endif
      mixed[127 - 32*(int'(col_cnt) + k) -: 32] = mix_fwd(col);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = RUN;
      RUN:     if (last_group) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the working register is reset because state_out must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      col_cnt <= '0;
`ifdef MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work    <= state_in;
          col_cnt <= '0;
`ifdef MIXCOL_INV_EN
          inv_q   <= mode;
`endif
        end
        RUN: begin
          work    <= mixed;
          col_cnt <= col_cnt + STEP;
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n so nothing is offered while the engine is held in reset.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_out = work;

endmodule

// File: doc/aes_mix_column_engine.md
# aes_mix_column_engine

Iterative AES column-mixing engine for the crypto datapath: it accepts a full 128-bit AES state and applies either MixColumns (encrypt) or InvMixColumns (decrypt) to all four columns. Columns are processed over 4/COLS_PER_CYCLE clock cycles. Valid/ready handshakes sit on both sides. It replaces the single-byte, decrypt-only combinational column logic and sits between the (Inv)ShiftRows and AddRoundKey stages of the round datapath.

## Interface
- COLS_PER_CYCLE, 1, number of columns transformed per RUN cycle; legal values 1, 2, 4.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  state_in/mode valid.
- in_ready  output  1  engine can accept a block.
- mode  input  1  0 = MixColumns, 1 = InvMixColumns; sampled at acceptance.
- state_in  input  128  column c occupies [127-32c -: 32]; within a column, byte a = MSB, then b, c, d.
- out_valid  output  1  state_out holds a finished block.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  transformed state, same packing as state_in.
- busy  output  1  high in RUN or DONE.

## Operation
- xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
- Forward column, with t = a^b^c^d:
  - a' = a^t^xtime(a^b)
  - b' = b^t^xtime(b^c)
  - c' = c^t^xtime(c^d)
  - d' = d^t^xtime(d^a)
- Inverse column:
  - u = xtime(xtime(a^c)), v = xtime(xtime(b^d)).
  - Pre-map a^=u, b^=v, c^=u, d^=v, then apply the forward column.
- All arithmetic is byte-wide GF(2^8); there is no carry out of a byte.
- FSM states are IDLE, RUN, and DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, load state_in into the working register, latch mode, clear col_cnt, and go to RUN.
  - RUN: each edge transforms columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place, and col_cnt advances by COLS_PER_CYCLE. On the edge that processes the last column, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE. state_out and out_valid hold stable while out_ready=0.
- in_ready is 0 in RUN and DONE. There is no acceptance overlap with output.
- Changes to in_valid, mode, and state_in outside IDLE are ignored.
- col_cnt is 2 bits and wraps 3→0 at the end of RUN.
- state_out is driven from the working register. Its value is defined only while out_valid=1.

## Timing
- Reset values: in_ready=1 after reset release (0 while rst_n=0), out_valid=0, busy=0, state_out=128'h0, FSM=IDLE, col_cnt=0.
- Let N = 4/COLS_PER_CYCLE and let acceptance be edge E0. out_valid rises after edge EN, i.e. latency is N cycles.
- If out_ready=1 during DONE, the handshake completes at E(N+1), and in_ready=1 from then on. Minimum block period is N+2 cycles.
- rst_n low mid-RUN or mid-DONE clears everything immediately. The in-flight block is discarded, and nothing is emitted after release.
- in_valid asserted in the same cycle as a DONE handshake is not accepted until the engine is back in IDLE.

## Configuration
- MIXCOL_INV_EN
  - Defined: the mode input selects forward/inverse as above, and the u/v pre-map logic is built.
  - Undefined: the pre-map logic is not compiled; mode is ignored and every block receives forward MixColumns.

## Test plan
- Forward test, COLS_PER_CYCLE=1, mode=0:
  - Stimulus: state_in=128'hdb135345_f20a225c_01010101_2d26314c.
  - Required: state_out=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8 with out_valid exactly 4 cycles after acceptance.
- Inverse test, MIXCOL_INV_EN defined, mode=1:
  - Stimulus: the output of the forward test.
  - Required: state_out returns to 128'hdb135345_f20a225c_01010101_2d26314c. Repeat with COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE → state_out and out_valid stable, in_ready=0 throughout. Raise out_ready → in_ready=1 next cycle.
- Reset mid-operation: assert rst_n=0 during the second RUN cycle → out_valid=0, state_out=0, and in_ready=1 after release. The next block (c6c6c6c6 ×4) returns c6c6c6c6 ×4.
- Without MIXCOL_INV_EN:
  - Stimulus: mode=1 with state_in=128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5.
  - Required: the forward result 128'hd5d5d7d6 repeated in all four columns.
